test_result_monitor: RTL and testbench

- Synthesisable bus snooper on the CPU memory bus, beside the mem block under top.
- Watches CPU writes to a result byte in zero page, e.g. address 169 / 0xA9.
- Detects end of test: the program parks in a jump-to-self loop, seen as repeated opcode fetches from one address.
- Raises a pass/fail verdict with a cycle count, so Suite A benches and the FPGA build share one end-of-test check instead of fixed delays.

---
 rtl/monitor_pkg.sv | 14 +
 rtl/trap_detector.sv | 44 ++++
 rtl/test_result_monitor.sv | 90 +++++++++
 tb/tb_test_result_monitor.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/monitor_pkg.sv
// rtl/monitor_pkg.sv - shared types and defaults for the end-of-test bus monitor
package monitor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_t;

    localparam logic [15:0] RESULT_ADDR_DEF = 16'h00A9;
    localparam logic [7:0]  EXPECT_DEF      = 8'hAA;

endpackage

// File: rtl/trap_detector.sv
// rtl/trap_detector.sv - spots a jump-to-self loop as repeated opcode fetches from one address
module trap_detector #(
    parameter int unsigned TRAP_REPEAT = 3
) (
    input  logic        ph2,
    input  logic        reset,
    input  logic        enable,
    input  logic        fetch,
    input  logic [15:0] address,
    output logic        hit
);

    localparam logic [3:0] TRAP_N = 4'(TRAP_REPEAT);

    logic [15:0] last_addr;
    logic [3:0]  count;
    logic [3:0]  count_nxt;

    // Operand/data cycles (fetch=0) inside the loop leave the run length alone.
    always_comb begin
        count_nxt = count;
        if (fetch) begin
            if (address == last_addr) begin
                count_nxt = (count == TRAP_N) ? count : count + 4'd1;
            end else begin
                count_nxt = 4'd1;
            end
        end
    end

    // Combinational so the FSM can act on the very edge the run completes.
    assign hit = enable && fetch && (count_nxt == TRAP_N) && (count != TRAP_N);

    always_ff @(posedge ph2) begin
        if (reset) begin
            last_addr <= 16'h0000;
            count     <= 4'd0;
        end else if (enable && fetch) begin
            last_addr <= address;
            count     <= count_nxt;
        end
    end

endmodule

// File: rtl/test_result_monitor.sv
// rtl/test_result_monitor.sv - CPU bus snooper producing a pass/fail verdict and cycle count
module test_result_monitor
    import monitor_pkg::*;
#(
    parameter logic [15:0] RESULT_ADDR = RESULT_ADDR_DEF,
    parameter logic [7:0]  EXPECT      = EXPECT_DEF,
    parameter int unsigned TRAP_REPEAT = 3,
    parameter logic [15:0] TIMEOUT     = 16'd400
) (
    input  logic        ph2,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [7:0]  data,
    input  logic        memwrite,
    input  logic        fetch,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic [7:0]  result,
    output logic [15:0] cycles,
    output logic [1:0]  state
);

    state_t     st;
    logic       result_valid;
    logic       running;
    logic       wr_hit;
    logic       trap_hit;
    logic       eff_valid;
    logic [7:0] eff_result;

    assign running = (st == RUN);
    assign wr_hit  = running && memwrite && (address == RESULT_ADDR);

    // A write landing on the same edge as the trap must count toward the verdict.
    assign eff_valid  = result_valid || wr_hit;
    assign eff_result = wr_hit ? data : result;

    trap_detector #(
        .TRAP_REPEAT(TRAP_REPEAT)
    ) u_trap (
        .ph2    (ph2),
        .reset  (reset),
        .enable (running),
        .fetch  (fetch),
        .address(address),
        .hit    (trap_hit)
    );

    always_ff @(posedge ph2) begin
        if (reset) begin
            st           <= IDLE;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            result       <= 8'h00;
            result_valid <= 1'b0;
            cycles       <= 16'd0;
        end else begin
            case (st)
                IDLE: st <= RUN;
                RUN: begin
                    cycles <= cycles + 16'd1;
                    if (wr_hit) begin
                        result       <= data;
                        result_valid <= 1'b1;
                    end
                    if (trap_hit) begin
                        done <= 1'b1;
                        if (eff_valid && (eff_result == EXPECT)) begin
                            st   <= PASS;
                            pass <= 1'b1;
                        end else begin
                            st   <= FAIL;
                            fail <= 1'b1;
                        end
                    end else if (cycles == TIMEOUT - 16'd1) begin
                        st   <= FAIL;
                        done <= 1'b1;
                        fail <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state = st;

endmodule

// File: tb/tb_test_result_monitor.sv
// tb/tb_test_result_monitor.sv - self-checking bench for test_result_monitor
module tb_test_result_monitor;

    logic        ph2 = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] address = 16'h0000;
    logic [7:0]  data = 8'h00;
    logic        memwrite = 1'b0;
    logic        fetch = 1'b0;

    logic        done_a, pass_a, fail_a, done_b, pass_b, fail_b;
    logic [7:0]  result_a, result_b;
    logic [15:0] cycles_a, cycles_b;
    logic [1:0]  state_a, state_b;

    int checks = 0;
    int errors = 0;

    always #5 ph2 = ~ph2;

    test_result_monitor #(.TIMEOUT(16'd400)) dut_a (
        .ph2(ph2), .reset(reset), .address(address), .data(data),
        .memwrite(memwrite), .fetch(fetch), .done(done_a), .pass(pass_a),
        .fail(fail_a), .result(result_a), .cycles(cycles_a), .state(state_a)
    );

    test_result_monitor #(.TIMEOUT(16'd20)) dut_b (
        .ph2(ph2), .reset(reset), .address(address), .data(data),
        .memwrite(memwrite), .fetch(fetch), .done(done_b), .pass(pass_b),
        .fail(fail_b), .result(result_b), .cycles(cycles_b), .state(state_b)
    );

    // Reference model: phase 0 idle, 1 running, 2 finished; verdict 1 pass, 2 fail.
    int          tmo [2] = '{400, 20};
    int          m_phase [2];
    int          m_verdict [2];
    int          m_cycles [2];
    int          m_run [2];
    logic [15:0] m_last [2];
    logic [7:0]  m_result [2];
    bit          m_valid [2];

    task automatic model_step(input int k, input bit rst, input logic [15:0] a,
                              input logic [7:0] d, input bit we, input bit fe);
        bit trap;
        if (rst) begin
            m_phase[k] = 0; m_verdict[k] = 0; m_cycles[k] = 0; m_run[k] = 0;
            m_last[k] = 16'h0000; m_result[k] = 8'h00; m_valid[k] = 0;
        end else if (m_phase[k] == 0) begin
            m_phase[k] = 1;
        end else if (m_phase[k] == 1) begin
            m_cycles[k]++;
            if (we && a == 16'h00A9) begin
                m_result[k] = d;
                m_valid[k] = 1;
            end
            trap = 0;
            if (fe) begin
                m_run[k] = (a == m_last[k]) ? ((m_run[k] >= 3) ? 3 : m_run[k] + 1) : 1;
                m_last[k] = a;
                trap = (m_run[k] == 3);
            end
            if (trap) begin
                m_verdict[k] = (m_valid[k] && m_result[k] == 8'hAA) ? 1 : 2;
                m_phase[k] = 2;
            end else if (m_cycles[k] == tmo[k]) begin
                m_verdict[k] = 2;
                m_phase[k] = 2;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int k);
        logic [1:0] st_exp;
        st_exp = (m_phase[k] == 0) ? 2'd0 : (m_phase[k] == 1) ? 2'd1 :
                 (m_verdict[k] == 1) ? 2'd2 : 2'd3;
        if (k == 0) begin
            chk("a_done",   32'(done_a),   32'(m_phase[0] == 2));
            chk("a_pass",   32'(pass_a),   32'(m_verdict[0] == 1));
            chk("a_fail",   32'(fail_a),   32'(m_verdict[0] == 2));
            chk("a_result", 32'(result_a), 32'(m_result[0]));
            chk("a_cycles", 32'(cycles_a), 32'(m_cycles[0]));
            chk("a_state",  32'(state_a),  32'(st_exp));
        end else begin
            chk("b_done",   32'(done_b),   32'(m_phase[1] == 2));
            chk("b_pass",   32'(pass_b),   32'(m_verdict[1] == 1));
            chk("b_fail",   32'(fail_b),   32'(m_verdict[1] == 2));
            chk("b_result", 32'(result_b), 32'(m_result[1]));
            chk("b_cycles", 32'(cycles_b), 32'(m_cycles[1]));
            chk("b_state",  32'(state_b),  32'(st_exp));
        end
    endtask

    // Drive one bus cycle, clock it, advance the model, then compare both instances.
    task automatic step(input bit rst, input logic [15:0] a, input logic [7:0] d,
                        input bit we, input bit fe);
        reset = rst; address = a; data = d; memwrite = we; fetch = fe;
        @(posedge ph2);
        model_step(0, rst, a, d, we, fe);
        model_step(1, rst, a, d, we, fe);
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    task automatic idle_cycle();
        step(0, 16'h1234, 8'h00, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 16'h0000, 8'h00, 0, 0);
        step(0, 16'h0000, 8'h00, 0, 0);
    endtask

    initial begin
        // Reset state
        do_reset();
        step(1, 16'h0000, 8'h00, 0, 0);
        chk("reset_state", 32'(state_a), 32'd0);
        chk("reset_done",  32'(done_a), 32'd0);

        // Pass: write at RUN cycle 50, three fetches at F020 spaced by two non-fetch cycles
        step(0, 16'h0000, 8'h00, 0, 0);
        for (int i = 1; i < 50; i++) idle_cycle();
        step(0, 16'h00A9, 8'hAA, 1, 0);
        for (int n = 0; n < 3; n++) begin
            step(0, 16'hF020, 8'h00, 0, 1);
            if (n < 2) begin
                idle_cycle();
                idle_cycle();
            end
        end
        chk("pass_pass",   32'(pass_a),   32'd1);
        chk("pass_result", 32'(result_a), 32'hAA);
        chk("pass_cycles", 32'(cycles_a), 32'd57);
        chk("pass_state",  32'(state_a),  32'd2);

        // Mismatch
        do_reset();
        step(0, 16'h00A9, 8'h55, 1, 0);
        for (int n = 0; n < 3; n++) step(0, 16'hC000, 8'h00, 0, 1);
        chk("mismatch_fail",   32'(fail_a),   32'd1);
        chk("mismatch_result", 32'(result_a), 32'h55);

        // No result written
        do_reset();
        step(0, 16'h00A8, 8'hAA, 1, 0);
        for (int n = 0; n < 3; n++) step(0, 16'hC100, 8'h00, 0, 1);
        chk("noresult_fail",   32'(fail_a),   32'd1);
        chk("noresult_result", 32'(result_a), 32'h00);

        // Timeout on the short-timeout instance
        do_reset();
        for (int i = 0; i < 24; i++) step(0, 16'(16'h3000 + i), 8'h00, 0, 1);
        step(0, 16'h00A9, 8'hAA, 1, 0);
        chk("timeout_fail",   32'(fail_b),   32'd1);
        chk("timeout_cycles", 32'(cycles_b), 32'd20);
        chk("timeout_result", 32'(result_b), 32'h00);

        // Write on the same edge as the completing fetch
        do_reset();
        step(0, 16'h00A9, 8'h00, 0, 1);
        step(0, 16'h00A9, 8'h00, 0, 1);
        step(0, 16'h00A9, 8'hAA, 1, 1);
        chk("simul_write_pass", 32'(pass_a), 32'd1);

        // Trap completing on the timeout edge wins
        do_reset();
        step(0, 16'h00A9, 8'hAA, 1, 0);
        for (int i = 2; i <= 17; i++) idle_cycle();
        for (int n = 0; n < 3; n++) step(0, 16'hE000, 8'h00, 0, 1);
        chk("trap_vs_timeout_pass",   32'(pass_b),   32'd1);
        chk("trap_vs_timeout_cycles", 32'(cycles_b), 32'd20);

        // Reset mid-run clears the partial trap
        do_reset();
        step(0, 16'h00A9, 8'hAA, 1, 0);
        step(0, 16'hF020, 8'h00, 0, 1);
        step(0, 16'hF020, 8'h00, 0, 1);
        step(1, 16'h0000, 8'h00, 0, 0);
        chk("midreset_state",  32'(state_a),  32'd0);
        chk("midreset_result", 32'(result_a), 32'h00);
        step(0, 16'h0000, 8'h00, 0, 0);
        chk("midreset_run", 32'(state_a), 32'd1);
        step(0, 16'hF020, 8'h00, 0, 1);
        chk("midreset_notrap", 32'(done_a), 32'd0);

        // Randomized segments against the model
        for (int seg = 0; seg < 8; seg++) begin
            do_reset();
            for (int i = 0; i < 40; i++) begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r < 5)
                    step(0, ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hF020, 8'h00, 0, 1);
                else if (r < 7)
                    step(0, 16'h00A9, ($urandom_range(0, 1) == 0) ? 8'hAA : 8'($urandom), 1,
                         ($urandom_range(0, 3) == 0));
                else if (r < 8)
                    step(0, 16'($urandom), 8'($urandom), 1, 0);
                else
                    idle_cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
